// File: rtl/regfile_wb_queue_if.sv
// Interface bundling the producer handshakes, register-file write port,
// forwarding lookups and occupancy of the write-back queue.
//
//   p0_*      pipeline producer (priority)   : valid/dest/data in, ready out
//   p1_*      multi-cycle producer           : valid/dest/data in, ready out
//   wb_stall  write port unavailable this cycle
//   rf_*      register-file write port (load/dest/data)
//   src_*     read-source lookups, hit_*/fwd_* forwarding results
//   count     occupied queue entries
//
// Modports: slave = the queue itself, master = whatever drives the producers
// and observes the write port.
interface regfile_wb_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             p0_valid;
  logic             p0_ready;
  logic [4:0]       p0_dest;
  logic [XLEN-1:0]  p0_data;

  logic             p1_valid;
  logic             p1_ready;
  logic [4:0]       p1_dest;
  logic [XLEN-1:0]  p1_data;

  logic             wb_stall;
  logic             rf_load;
  logic [4:0]       rf_dest;
  logic [XLEN-1:0]  rf_data;

  logic [4:0]       src_a;
  logic [4:0]       src_b;
  logic             hit_a;
  logic [XLEN-1:0]  fwd_a;
  logic             hit_b;
  logic [XLEN-1:0]  fwd_b;

  logic [CNT_W-1:0] count;

  modport slave (
    input  p0_valid, p0_dest, p0_data,
    input  p1_valid, p1_dest, p1_data,
    input  wb_stall, src_a, src_b,
    output p0_ready, p1_ready,
    output rf_load, rf_dest, rf_data,
    output hit_a, fwd_a, hit_b, fwd_b,
    output count
  );

  modport master (
    output p0_valid, p0_dest, p0_data,
    output p1_valid, p1_dest, p1_data,
    output wb_stall, src_a, src_b,
    input  p0_ready, p1_ready,
    input  rf_load, rf_dest, rf_data,
    input  hit_a, fwd_a, hit_b, fwd_b,
    input  count
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// Write-side feeder for the 32x32 register file.
//
// Two producers (pipeline p0 with priority, multi-cycle unit p1) push
// {dest, data} results into a DEPTH-entry FIFO; one entry retires per cycle
// onto the register-file write port unless wb_stall holds it. Buffered values
// are forwarded combinationally to two read sources, youngest match winning.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous, active-low reset
//   bus  - regfile_wb_queue_if.slave (producers, write port, lookups, count)
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Entries stay in registers rather than block RAM: forwarding compares
  // every slot against both read sources in the same cycle.
  logic [4:0]       dest_mem [DEPTH];
  logic [XLEN-1:0]  data_mem [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic             not_full;
  logic             head_valid;
  logic             enq_fire;
  logic             enq_store;
  logic             deq_fire;
  logic [4:0]       enq_dest;
  logic [XLEN-1:0]  enq_data;

  logic [DEPTH-1:0] match_a;
  logic [DEPTH-1:0] match_b;
  logic             hit_a;
  logic             hit_b;
  logic [XLEN-1:0]  fwd_a;
  logic [XLEN-1:0]  fwd_b;

  // ---------------------------------------------------------------------
  // Enqueue side. Full blocks acceptance even if the head retires this
  // cycle, so ready never depends on wb_stall.
  // ---------------------------------------------------------------------
  assign not_full     = (count_reg < DEPTH_C);
  assign bus.p0_ready = not_full;
  assign bus.p1_ready = not_full && !bus.p0_valid;

  always_comb begin
    enq_dest = bus.p1_dest;
    enq_data = bus.p1_data;
    if (bus.p0_valid) begin
      enq_dest = bus.p0_dest;
      enq_data = bus.p0_data;
    end
  end

  assign enq_fire  = (bus.p0_valid || bus.p1_valid) && not_full;
  // Writes to x0 complete the handshake but are dropped here.
  assign enq_store = enq_fire && (enq_dest != 5'd0);

  // ---------------------------------------------------------------------
  // Dequeue side. An empty queue never retires, so an entry accepted into
  // an empty queue appears on the write port one cycle later at the earliest.
  // ---------------------------------------------------------------------
  assign head_valid  = (count_reg != '0);
  assign deq_fire    = head_valid && !bus.wb_stall;
  assign bus.rf_load = deq_fire;
  assign bus.rf_dest = head_valid ? dest_mem[rd_ptr_reg] : 5'd0;
  assign bus.rf_data = head_valid ? data_mem[rd_ptr_reg] : '0;
  assign bus.count   = count_reg;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq_store) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deq_fire)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({enq_store, deq_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Enqueue and dequeue never hit the same slot: that would need the queue
  // to be full (enqueue blocked) or empty (dequeue blocked).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_store && (wr_ptr_reg == PTR_W'(i))) begin
          valid_reg[i] <= 1'b1;
        end else if (deq_fire && (rd_ptr_reg == PTR_W'(i))) begin
          valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Payload needs no reset: every read of it is qualified by count/valid.
  always_ff @(posedge clk) begin
    if (enq_store) begin
      dest_mem[wr_ptr_reg] <= enq_dest;
      data_mem[wr_ptr_reg] <= enq_data;
    end
  end

  // ---------------------------------------------------------------------
  // Forwarding. Per-slot match flags, then a walk from the head (oldest)
  // toward the tail so the last match seen is the youngest. The head still
  // matches in the cycle it is being written to the register file.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match_a[gi] = valid_reg[gi] && (bus.src_a != 5'd0) && (dest_mem[gi] == bus.src_a);
      assign match_b[gi] = valid_reg[gi] && (bus.src_b != 5'd0) && (dest_mem[gi] == bus.src_b);
    end
  endgenerate

  always_comb begin
    logic [PTR_W-1:0] idx;
    idx   = '0;
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_reg + PTR_W'(k);
      if (match_a[idx]) begin
        hit_a = 1'b1;
        fwd_a = data_mem[idx];
      end
      if (match_b[idx]) begin
        hit_b = 1'b1;
        fwd_b = data_mem[idx];
      end
    end
  end

  assign bus.hit_a = hit_a;
  assign bus.fwd_a = fwd_a;
  assign bus.hit_b = hit_b;
  assign bus.fwd_b = fwd_b;

endmodule
